// File: rtl/if_id_pkg.sv
// ---------------------------------------------------------------------------
// if_id_pkg
// Shared definitions for the fetch->decode boundary.
//   IF_ID_ADDR_W  : default PC width
//   IF_ID_INSTR_W : default instruction width
//   NOP_INSTR     : canonical NOP (addi x0, x0, 0) shown when no entry is valid
//   if_id_entry_t : {pc, instr} pair as buffered by the queue and consumed
//                   by the decode stage
// ---------------------------------------------------------------------------
package if_id_pkg;

    localparam int IF_ID_ADDR_W  = 64;
    localparam int IF_ID_INSTR_W = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [IF_ID_ADDR_W-1:0]  pc;
        logic [IF_ID_INSTR_W-1:0] instr;
    } if_id_entry_t;

endpackage : if_id_pkg

// File: rtl/fifo_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ptr_ctrl
// Pointer/occupancy controller for a DEPTH-entry FIFO (DEPTH a power of two).
// Ports:
//   clk, reset (async, active-low), flush (sync clear)
//   push_req  : producer offers an entry (in_valid)
//   pop_req   : consumer accepts the head (out_ready)
//   in_ready  : queue can accept an entry this cycle
//   out_valid : head entry is available this cycle
//   push, pop : handshakes that complete at the next rising edge
//   wr_ptr, rd_ptr : storage indices
//   count     : occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module fifo_ptr_ctrl #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push_req,
    input  logic             pop_req,
    output logic             in_ready,
    output logic             out_valid,
    output logic             push,
    output logic             pop,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             full;
    logic             empty;

    // Pointers alone cannot tell full from empty once they wrap; count does.
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // Flush masks both handshakes so nothing completes on the clearing edge.
    // A full queue refuses input even if a pop happens in the same cycle.
    assign in_ready  = !full  && !flush;
    assign out_valid = !empty && !flush;
    assign push      = push_req && in_ready;
    assign pop       = pop_req  && out_valid;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;

endmodule : fifo_ptr_ctrl

// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
// Instruction buffer between fetch and decode. Holds fetched {pc, instr}
// pairs across decode stalls; flush (branch taken) drops every buffered
// entry so wrong-path instructions never reach decode. Strict FIFO order,
// no in->out bypass (an entry is visible the cycle after it is pushed).
// Ports:
//   clk, reset (async, active-low), flush (sync)
//   in_valid/in_ready, in_pc, in_instr      : fetch side
//   out_valid/out_ready, out_pc, out_instr  : decode side (0 / NOP when idle)
//   count                                   : occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module if_id_queue
    import if_id_pkg::*;
#(
    parameter  int DEPTH   = 4,
    parameter  int ADDR_W  = IF_ID_ADDR_W,
    parameter  int INSTR_W = IF_ID_INSTR_W,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ADDR_W-1:0]  in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CNT_W-1:0]   count
);

    logic             push;
    logic             pop;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    fifo_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ptr_ctrl (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push_req  (in_valid),
        .pop_req   (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .push      (push),
        .pop       (pop),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (count)
    );

    // Storage uses the shared entry layout; it is never reset because the
    // occupancy count alone decides what is visible.
    if_id_entry_t mem_q [DEPTH];
    if_id_entry_t wr_entry_d;
    if_id_entry_t head_entry;

    always_comb begin
        wr_entry_d       = '0;
        wr_entry_d.pc    = IF_ID_ADDR_W'(in_pc);
        wr_entry_d.instr = IF_ID_INSTR_W'(in_instr);
    end

    // Written only on a completed push, so X on the inputs while
    // in_valid=0 never enters the storage.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr] <= wr_entry_d;
        end
    end

    assign head_entry = mem_q[rd_ptr];

    always_comb begin
        out_pc    = '0;
        out_instr = INSTR_W'(NOP_INSTR);
        if (out_valid) begin
            out_pc    = ADDR_W'(head_entry.pc);
            out_instr = INSTR_W'(head_entry.instr);
        end
    end

    // pop is consumed inside the controller; kept visible for debug probes.
    logic pop_unused;
    assign pop_unused = pop;

endmodule : if_id_queue

// File: tb/tb_if_id_queue.sv
// ---------------------------------------------------------------------------
// tb_if_id_queue
// Directed bench for if_id_queue (DEPTH=4, ADDR_W=64, INSTR_W=32).
// ---------------------------------------------------------------------------
module tb_if_id_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_pc    = '0;
    logic [31:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    if_id_queue #(
        .DEPTH   (4),
        .ADDR_W  (64),
        .INSTR_W (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [63:0] pc);
        return {16'hA5C3, pc[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = mk_instr(pc);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [63:0] pc);
        out_ready = 1'b1;
        #1;
        check({tag, "_vld"},   64'(out_valid), 64'(1));
        check({tag, "_pc"},    out_pc, pc);
        check({tag, "_instr"}, 64'(out_instr), 64'(mk_instr(pc)));
        tick();
        out_ready = 1'b0;
    endtask

    logic [63:0] exp_q[$];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset with in_valid held high
        in_valid = 1'b1;
        in_pc    = 64'h100;
        in_instr = mk_instr(64'h100);
        #2 reset = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_count",  64'(count),     64'(0));
        check("rst_oval",   64'(out_valid), 64'(0));
        check("rst_irdy",   64'(in_ready),  64'(1));
        check("rst_instr",  64'(out_instr), 64'(NOP));
        check("rst_pc",     out_pc,         64'(0));
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        check("post_rst_count", 64'(count),     64'(0));
        check("post_rst_oval",  64'(out_valid), 64'(0));

        // ---------------- X on idle inputs must not reach the outputs
        in_pc    = 'x;
        in_instr = 'x;
        tick();
        check("x_pc",    out_pc,         64'(0));
        check("x_instr", 64'(out_instr), 64'(NOP));
        check("x_count", 64'(count),     64'(0));

        // ---------------- fill to full, 5th push ignored, drain in order
        push(64'h0);
        check("lat_head_pc", out_pc, 64'h0);
        push(64'h4);
        push(64'h8);
        push(64'hC);
        check("full_count", 64'(count),    64'(4));
        check("full_irdy",  64'(in_ready), 64'(0));
        push(64'h10);
        check("full_ovf_count", 64'(count), 64'(4));
        pop_expect("drain0", 64'h0);
        pop_expect("drain1", 64'h4);
        pop_expect("drain2", 64'h8);
        pop_expect("drain3", 64'hC);
        out_ready = 1'b1;
        #1;
        check("empty_count", 64'(count),     64'(0));
        check("empty_oval",  64'(out_valid), 64'(0));
        tick();
        check("empty_no_underflow", 64'(count), 64'(0));
        out_ready = 1'b0;

        // ---------------- simultaneous push/pop at count=2
        push(64'h40);
        push(64'h44);
        in_valid  = 1'b1;
        in_pc     = 64'h48;
        in_instr  = mk_instr(64'h48);
        out_ready = 1'b1;
        #1;
        check("sim_pop_pc", out_pc, 64'h40);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("sim_count", 64'(count), 64'(2));
        pop_expect("sim_d0", 64'h44);
        pop_expect("sim_d1", 64'h48);

        // ---------------- flush with 3 entries and a concurrent push offer
        push(64'h50);
        push(64'h54);
        push(64'h58);
        check("pre_flush_count", 64'(count), 64'(3));
        flush    = 1'b1;
        in_valid = 1'b1;
        in_pc    = 64'h20;
        in_instr = mk_instr(64'h20);
        #1;
        check("flush_irdy",  64'(in_ready),  64'(0));
        check("flush_oval",  64'(out_valid), 64'(0));
        check("flush_instr", 64'(out_instr), 64'(NOP));
        tick();
        flush = 1'b0;
        #1;
        check("post_flush_count", 64'(count),     64'(0));
        check("post_flush_oval",  64'(out_valid), 64'(0));
        tick();
        in_valid = 1'b0;
        check("flush_head_count", 64'(count), 64'(1));
        pop_expect("flush_head", 64'h20);

        // ---------------- wrap-around stream, out_ready toggling
        begin
            int  sent = 0;
            int  rcvd = 0;
            int  cyc  = 0;
            bit  m_push;
            bit  m_pop;
            exp_q.delete();
            while (rcvd < 10 && cyc < 100) begin
                in_valid  = (sent < 10);
                in_pc     = 64'(sent * 4);
                in_instr  = mk_instr(64'(sent * 4));
                out_ready = (cyc % 2 == 1);
                #1;
                check("wrap_count", 64'(count),     64'(exp_q.size()));
                check("wrap_irdy",  64'(in_ready),  64'(exp_q.size() != 4));
                check("wrap_oval",  64'(out_valid), 64'(exp_q.size() != 0));
                m_push = in_valid && (exp_q.size() != 4);
                m_pop  = out_ready && (exp_q.size() != 0);
                if (m_pop) begin
                    check("wrap_pc",    out_pc,         exp_q[0]);
                    check("wrap_instr", 64'(out_instr), 64'(mk_instr(exp_q[0])));
                    void'(exp_q.pop_front());
                    rcvd++;
                end
                if (m_push) begin
                    exp_q.push_back(64'(sent * 4));
                    sent++;
                end
                tick();
                cyc++;
            end
            check("wrap_received", 64'(rcvd), 64'(10));
            in_valid  = 1'b0;
            out_ready = 1'b0;
        end

        // ---------------- asynchronous reset mid-cycle with 2 entries
        push(64'h70);
        push(64'h74);
        check("pre_arst_count", 64'(count), 64'(2));
        #2 reset = 1'b0;
        #1;
        check("arst_oval",  64'(out_valid), 64'(0));
        check("arst_count", 64'(count),     64'(0));
        check("arst_pc",    out_pc,         64'(0));
        #2 reset = 1'b1;
        tick();
        push(64'h60);
        check("post_arst_count", 64'(count), 64'(1));
        pop_expect("post_arst_head", 64'h60);
        #1;
        check("final_count", 64'(count), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_if_id_queue

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Small instruction buffer between the instruction fetch stage and the decode stage.
- Captures each fetched {PC, instruction} pair and holds it until decode accepts it, so a decode stall does not drop fetched words.
- A flush input discards all buffered entries when a branch is taken, so wrong-path instructions never reach decode.
- Valid/ready handshake on both sides; FIFO ordering is strict.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- ADDR_W, 64, PC width.
- INSTR_W, 32, instruction width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous reset, active-low (reset=0 clears the block).
- flush  in  1  synchronous flush, driven by the branch-taken signal.
- in_valid  in  1  fetch presents an entry.
- in_ready  out  1  queue can accept an entry.
- in_pc  in  ADDR_W  PC of the incoming instruction.
- in_instr  in  INSTR_W  incoming instruction word.
- out_valid  out  1  head entry available to decode.
- out_ready  in  1  decode accepts the head entry.
- out_pc  out  ADDR_W  PC of the head entry.
- out_instr  out  INSTR_W  head instruction word.
- count  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (reset=0, asynchronous): wr_ptr, rd_ptr and count clear immediately.
  - out_valid=0, in_ready=1, out_pc=0, out_instr=32'h00000013 (NOP).
  - Entry storage contents need not be cleared.
- Push: occurs on a rising edge when in_valid && in_ready. Writes mem[wr_ptr] and increments wr_ptr modulo DEPTH.
- Pop: occurs on a rising edge when out_valid && out_ready. Increments rd_ptr modulo DEPTH.
- count update: +1 for push only, -1 for pop only, unchanged when both or neither occur.
- in_ready = (count != DEPTH) && !flush. There is no pop-bypass: a full queue refuses input even while a pop happens in the same cycle.
- out_valid = (count != 0) && !flush.
- out_pc/out_instr:
  - When out_valid=1, show mem[rd_ptr] combinationally.
  - Otherwise show 0 / NOP.
- Latency: a pushed entry first appears at the output the cycle after the push edge. There is no same-cycle in-to-out bypass.
- Flush: at a rising edge with flush=1, wr_ptr, rd_ptr and count clear. Because in_ready and out_valid are forced to 0 while flush=1, no push or pop completes that cycle. The next cycle behaves as empty.
- Full: in_ready=0; in_valid is ignored; data is not overwritten.
- Empty: out_valid=0; out_ready is ignored; count never underflows.
- Wrap-around: pointers are clog2(DEPTH) bits and wrap naturally. count disambiguates full from empty.
- Simultaneous push and pop on a partially filled queue: both occur, count is unchanged, ordering is preserved.
- Reset asserted mid-operation: the queue empties immediately regardless of clk. After reset is released, the first push lands in entry 0.
- X on in_pc/in_instr while in_valid=0 must not propagate to the outputs.

Decomposition:
- Shared package if_id_pkg holds:
  - NOP_INSTR = 32'h00000013.
  - Default ADDR_W and INSTR_W.
  - Typedef if_id_entry_t {pc, instr}, used for the storage array and reused by the decode stage.
- One sub-module, fifo_ptr_ctrl: parameterised by DEPTH, it owns wr_ptr, rd_ptr, count, the full/empty flags and the flush/reset clearing logic.
- if_id_queue instantiates fifo_ptr_ctrl and adds the entry storage and the output muxing.

Test Plan:
- Reset: assert reset=0 for 2 cycles with in_valid=1 -> count=0, out_valid=0, in_ready=1, out_instr=00000013, out_pc=0. Release reset -> no spurious entry appears.
- Fill to full, out_ready=0: push PCs 0x0, 0x4, 0x8, 0xC with distinct instructions -> count reaches 4 and in_ready=0. A 5th push (PC 0x10) is ignored. Draining gives 0x0, 0x4, 0x8, 0xC in order.
- Simultaneous push/pop at count=2 -> count stays 2. The popped PC is the oldest; the new entry appears after the existing ones.
- Flush: with 3 entries queued, pulse flush with in_valid=1 and in_ipc 0x20 -> during the flush cycle in_ready=0 and out_valid=0. Afterwards count=0. The next push of PC 0x20 becomes the head one cycle later.
- Wrap-around: stream 10 entries (PC 0x0..0x24) with out_ready toggling every other cycle -> output order matches input order exactly, and count never exceeds 4 or goes below 0.
- Reset mid-operation: with 2 entries queued, assert reset between clock edges -> out_valid drops to 0 asynchronously, before the next edge. After release, the first push of PC 0x60 is returned first.
